// File: rtl/spi_slave_gen.sv
// Parametrised SPI slave: any CPOL/CPHA mode, configurable word width and bit order,
// one-word TX buffer and RX holding register. Define SPIS_OVERRUN_EN for a sticky overrun flag.
module spi_slave_gen #(
    parameter int DATA_W      = 8,
    parameter bit CPOL        = 1'b1,
    parameter bit CPHA        = 1'b1,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cs,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int             CW   = $clog2(DATA_W);
    localparam logic [CW-1:0]  LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {S_RESYNC, S_IDLE, S_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic [SYNC_STAGES:0]   flush_pipe;
    logic                   sck_s, cs_s, mosi_s, sck_d, flushed;
    state_t                 state, state_nxt;
    logic                   cs_fall, cs_rise, edge_en;
    logic                   lead_e, trail_e, sample_e, shift_e;

    logic [DATA_W-1:0]      tx_buf, tx_sh, tx_sh_nxt, load_word;
    logic                   tx_full, tx_load, tx_shift, miso_nxt;
    logic [CW-1:0]          tx_cnt;

    logic [DATA_W-1:0]      rx_sh, rx_sh_nxt;
    logic [CW-1:0]          rx_cnt;
    logic                   rx_done;

    // Reset values match the idle bus so releasing reset creates no edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_sync   <= {SYNC_STAGES{CPOL}};
            cs_sync    <= '1;
            mosi_sync  <= '0;
            sck_d      <= CPOL;
            flush_pipe <= '0;
        end else begin
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d      <= sck_s;
            flush_pipe <= {flush_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign flushed = flush_pipe[SYNC_STAGES];

    // Frame tracker: after reset a frame only starts once a genuine cs-high has been seen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_RESYNC;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESYNC: if (flushed && cs_s) state_nxt = S_IDLE;
            S_IDLE:   if (!cs_s)           state_nxt = S_ACTIVE;
            S_ACTIVE: if (cs_s)            state_nxt = S_IDLE;
            default:                       state_nxt = S_RESYNC;
        endcase
    end

    always_comb begin
        cs_fall = 1'b0;
        cs_rise = 1'b0;
        edge_en = 1'b0;
        case (state)
            S_IDLE:   cs_fall = !cs_s;
            S_ACTIVE: begin
                cs_rise = cs_s;
                edge_en = !cs_s;
            end
            default: ;
        endcase
    end

    assign lead_e   = edge_en && (sck_d == CPOL) && (sck_s != CPOL);
    assign trail_e  = edge_en && (sck_d != CPOL) && (sck_s == CPOL);
    assign sample_e = CPHA ? trail_e : lead_e;
    assign shift_e  = CPHA ? lead_e  : trail_e;

    // TX path
    assign tx_ready  = !tx_full;
    assign load_word = tx_full ? tx_buf : '1;
    assign tx_load   = (shift_e && (tx_cnt == '0)) || (cs_fall && !CPHA);
    assign tx_shift  = shift_e && (tx_cnt != '0);

    always_comb begin
        tx_sh_nxt = tx_sh;
        if (tx_load)
            tx_sh_nxt = load_word;
        else if (tx_shift)
            tx_sh_nxt = MSB_FIRST ? {tx_sh[DATA_W-2:0], 1'b1} : {1'b1, tx_sh[DATA_W-1:1]};
    end

    assign miso_nxt = MSB_FIRST ? tx_sh_nxt[DATA_W-1] : tx_sh_nxt[0];

    // A write only lands when empty, so a same-cycle load already saw the old (empty) state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_full <= 1'b0;
            tx_buf  <= '0;
        end else if (tx_valid && !tx_full) begin
            tx_full <= 1'b1;
            tx_buf  <= tx_data;
        end else if (tx_load) begin
            tx_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_sh  <= '1;
            tx_cnt <= '0;
            miso   <= 1'b1;
        end else begin
            tx_sh <= tx_sh_nxt;
            if (cs_rise) begin
                tx_cnt <= '0;
                miso   <= 1'b1;
            end else if (cs_fall && !CPHA) begin
                tx_cnt <= CW'(1);
                miso   <= miso_nxt;
            end else if (shift_e) begin
                tx_cnt <= (tx_cnt == LAST) ? '0 : tx_cnt + CW'(1);
                miso   <= miso_nxt;
            end
        end
    end

    // RX path
    assign rx_sh_nxt = MSB_FIRST ? {rx_sh[DATA_W-2:0], mosi_s} : {mosi_s, rx_sh[DATA_W-1:1]};
    assign rx_done   = sample_e && (rx_cnt == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_sh  <= '0;
            rx_cnt <= '0;
        end else if (cs_rise) begin
            rx_cnt <= '0;
        end else if (sample_e) begin
            rx_sh  <= rx_sh_nxt;
            rx_cnt <= rx_done ? '0 : rx_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (rx_done) begin
            rx_data  <= rx_sh_nxt;
            rx_valid <= 1'b1;
        end else if (rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) miso_oe <= 1'b0;
        else       miso_oe <= !cs_s;
    end

`ifdef SPIS_OVERRUN_EN
    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            overrun <= 1'b0;
        else if (rx_done && rx_valid && !rx_ready)
            overrun <= 1'b1;
        else if (ovr_clr)
            overrun <= 1'b0;
    end
`else
    logic ovr_clr_unused;
    assign ovr_clr_unused = ovr_clr;
    assign overrun        = 1'b0;
`endif

endmodule

// File: doc/spi_slave_gen.md
# spi_slave_gen

Parametrised SPI slave: the successor to the fixed 8-bit, mode-3-only slave. It supports configurable word width, all four CPOL/CPHA modes, and MSB- or LSB-first order. It uses valid/ready handshakes on both the transmit and receive sides, resynchronises the frame on chip-select, and optionally flags overrun. It sits between an external SPI master and the on-chip register/command logic, and oversamples all SPI pins on the system clock.

## Interface
- DATA_W, 8: bits per word (2..32)
- CPOL, 1: sck idle level
- CPHA, 1: 0 = sample on leading edge; 1 = sample on trailing edge
- MSB_FIRST, 1: 1 = MSB first; 0 = LSB first
- SYNC_STAGES, 2: synchroniser depth for sck/cs/mosi (≥2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- cs  in  1  chip select, active low
- sck  in  1  SPI clock from master
- mosi  in  1  serial data in
- miso  out  1  serial data out; reset 1
- miso_oe  out  1  high while synchronised cs is low; reset 0
- tx_data  in  DATA_W  next word to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  tx buffer empty; reset 1
- rx_data  out  DATA_W  last received word; reset 0
- rx_valid  out  1  rx_data unread; reset 0
- rx_ready  in  1  consumer accepts rx_data
- overrun  out  1  sticky overrun flag; reset 0
- ovr_clr  in  1  clears overrun

## Operation
- Synchronisers:
  - sck, cs and mosi each pass through SYNC_STAGES flops.
  - Reset values: sck chain = CPOL, cs chain = 1, mosi chain = 0, so reset release produces no spurious edge.
- Edge detection:
  - Leading edge = transition away from CPOL; trailing edge = transition back to it.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other edge.
  - Edges are ignored while synchronised cs is high.
- TX buffer:
  - One word deep.
  - A write (tx_valid && tx_ready) fills it, and tx_ready drops the next cycle.
  - The buffer empties when its word is loaded into the shifter.
- TX shifter, counter tx_cnt:
  - Load: buffer word if full, else all-ones (underrun). miso = first bit.
  - CPHA=0: cs falling loads and sets tx_cnt=1.
  - On every shift edge: if tx_cnt==0, load; else shift out the next bit. Then tx_cnt = (tx_cnt+1) mod DATA_W.
- RX shifter, counter rx_cnt:
  - Each sample edge captures mosi into the bit position given by MSB_FIRST and increments rx_cnt.
  - On bit DATA_W-1: rx_data ← the completed word, rx_valid ← 1, rx_cnt ← 0.
- RX handshake: rx_valid clears on rx_valid && rx_ready.
- cs rising (synchronised):
  - rx_cnt and tx_cnt reset to 0; partial RX bits are discarded with no rx_valid.
  - A word already loaded into the TX shifter stays consumed.
  - miso ← 1.
- Simultaneous events:
  - A TX load sees the buffer state before a same-cycle write; the write lands in the buffer for the next word.
  - Word completion in the same cycle as an rx_ready handshake: the new word is stored, rx_valid stays 1, no overrun.
  - ovr_clr in the same cycle as a new overrun: overrun stays set.
- Reset mid-frame: all state returns to reset values; the first edge after release is ignored until cs is seen high and then low.

## Timing
- Input-to-internal latency: SYNC_STAGES + 1 clk cycles (synchroniser + edge register).
- miso updates 1 clk after the detected shift edge.
- rx_valid rises 1 clk after the detected final sample edge.
- tx_ready rises 1 clk after a load.
- sck high and low phases must each be ≥ SYNC_STAGES+2 clk cycles.
- cs setup before the first sck edge must be ≥ SYNC_STAGES+2 clk cycles.

## Configuration
- SPIS_OVERRUN_EN defined:
  - A word completing while rx_valid=1 with no same-cycle handshake overwrites rx_data and sets overrun.
  - overrun holds until ovr_clr.
- SPIS_OVERRUN_EN not defined:
  - overrun is tied to 0 and ovr_clr is ignored.
  - rx_data is still overwritten silently.

## Test plan
- Mode 3, DATA_W=8, MSB_FIRST: preload tx 0xA5, master sends 0x3C → rx_data=0x3C with rx_valid for one word; master receives 0xA5.
- Modes 0/1/2, DATA_W=16, LSB_FIRST: master sends 0x1234 in each mode → rx_data=0x1234 and master receives the preloaded 0xBEEF in every mode.
- No tx write before frame: master clocks 8 bits → master receives 0xFF; a tx_data=0x11 written mid-word is sent as the next word.
- cs raised after 5 bits, then full frame 0x81 → no rx_valid for the partial word; rx_data=0x81 and bit counters realigned.
- SPIS_OVERRUN_EN defined, rx_ready held 0, two words 0x01, 0x02 → rx_data=0x02, overrun=1; ovr_clr pulse → overrun=0.
- Assert rstn low mid-word → miso=1, tx_ready=1, rx_valid=0, overrun=0; the next full frame is received correctly.
